// File: rtl/shift_reg_q.sv
// shift_reg_q: WIDTH-bit operand register for sequential mul/div datapaths.
// Supports init to a constant, parallel load, single-bit shift left/right
// with serial fill, and a built-in shift counter that saturates at NSHIFT
// and raises done, so the controlling FSM needs no bit counter of its own.
module shift_reg_q #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] INIT_VAL = 'h00FF,
  parameter int               NSHIFT   = WIDTH,
  localparam int              CW       = $clog2(NSHIFT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             ld,
  input  logic             shl,
  input  logic             shr,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] reg_in,
  output logic [WIDTH-1:0] reg_out,
  output logic             msb_out,
  output logic             lsb_out,
  output logic [CW-1:0]    shift_cnt,
  output logic             done,
  output logic             err
);

  localparam logic [CW-1:0] NSHIFT_C = CW'(NSHIFT);

  // COUNTING while fewer than NSHIFT shifts have happened; SATURATED once the
  // final shift lands. The state register doubles as the registered done flag.
  typedef enum logic {
    ST_COUNTING  = 1'b0,
    ST_SATURATED = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic [CW-1:0]    r_cnt;
  logic             r_err;

  logic [CW-1:0]    w_cnt_inc;
  logic [WIDTH-1:0] w_shl_data;
  logic [WIDTH-1:0] w_shr_data;

  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_shl_data = {r_data[WIDTH-2:0], ser_in};
  assign w_shr_data = {ser_in, r_data[WIDTH-1:1]};

  // Command decode with priority init > ld > conflict > shl > shr > hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_COUNTING;
      r_data  <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else if (init) begin
      r_state <= ST_COUNTING;
      r_data  <= INIT_VAL;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else if (ld) begin
      r_state <= ST_COUNTING;
      r_data  <= reg_in;
      r_cnt   <= '0;
    end else if (shl && shr) begin
      // Contradictory request: keep the operand intact and flag it stickily.
      r_err <= 1'b1;
    end else if ((shl || shr) && (r_state == ST_COUNTING)) begin
      r_data  <= shl ? w_shl_data : w_shr_data;
      r_cnt   <= w_cnt_inc;
      r_state <= (w_cnt_inc == NSHIFT_C) ? ST_SATURATED : ST_COUNTING;
    end
  end

  assign reg_out   = r_data;
  assign msb_out   = r_data[WIDTH-1];
  assign lsb_out   = r_data[0];
  assign shift_cnt = r_cnt;
  assign done      = (r_state == ST_SATURATED);
  assign err       = r_err;

endmodule

// File: tb/tb_shift_reg_q.sv
// Bench for shift_reg_q: a vector table on the default 16-bit instance plus
// hand-written sequences for async reset and a small 8-bit/NSHIFT=3 instance.
module tb_shift_reg_q;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- 16-bit instance (defaults) ----------------
  logic        rst, init, ld, shl, shr, ser_in;
  logic [15:0] reg_in, reg_out;
  logic        msb_out, lsb_out, done, err;
  logic [4:0]  shift_cnt;

  shift_reg_q dut (
    .clk(clk), .rst(rst), .init(init), .ld(ld), .shl(shl), .shr(shr),
    .ser_in(ser_in), .reg_in(reg_in), .reg_out(reg_out), .msb_out(msb_out),
    .lsb_out(lsb_out), .shift_cnt(shift_cnt), .done(done), .err(err)
  );

  // ---------------- 8-bit instance, NSHIFT=3 ----------------
  logic       s_rst, s_init, s_ld, s_shl, s_shr, s_ser_in;
  logic [7:0] s_reg_in, s_reg_out;
  logic       s_msb_out, s_lsb_out, s_done, s_err;
  logic [1:0] s_shift_cnt;

  shift_reg_q #(.WIDTH(8), .INIT_VAL(8'h0F), .NSHIFT(3)) dut_s (
    .clk(clk), .rst(s_rst), .init(s_init), .ld(s_ld), .shl(s_shl), .shr(s_shr),
    .ser_in(s_ser_in), .reg_in(s_reg_in), .reg_out(s_reg_out),
    .msb_out(s_msb_out), .lsb_out(s_lsb_out), .shift_cnt(s_shift_cnt),
    .done(s_done), .err(s_err)
  );

  typedef struct {
    logic        init, ld, shl, shr, ser_in;
    logic [15:0] reg_in;
    logic [15:0] exp_out;
    int          exp_cnt;
    logic        exp_done, exp_err;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic void add(input logic i, input logic l, input logic sl, input logic sr,
                              input logic si, input logic [15:0] rin, input logic [15:0] eout,
                              input int ecnt, input logic ed, input logic ee);
    vec_t v;
    v.init = i; v.ld = l; v.shl = sl; v.shr = sr; v.ser_in = si; v.reg_in = rin;
    v.exp_out = eout; v.exp_cnt = ecnt; v.exp_done = ed; v.exp_err = ee;
    tbl.push_back(v);
  endfunction

  // Drive one vector for a single edge, queue its expectation, then pop and
  // compare once the DUT has produced the post-edge state.
  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    string nm;
    @(negedge clk);
    init = v.init; ld = v.ld; shl = v.shl; shr = v.shr; ser_in = v.ser_in; reg_in = v.reg_in;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    nm = $sformatf("vec%0d", idx);
    chk({nm, ".reg_out"}, 32'(reg_out), 32'(e.exp_out));
    chk({nm, ".cnt"},     32'(shift_cnt), 32'(e.exp_cnt));
    chk({nm, ".done"},    32'(done), 32'(e.exp_done));
    chk({nm, ".err"},     32'(err), 32'(e.exp_err));
    chk({nm, ".msb"},     32'(msb_out), 32'(e.exp_out[15]));
    chk({nm, ".lsb"},     32'(lsb_out), 32'(e.exp_out[0]));
    $display("vec%0d init=%0b ld=%0b shl=%0b shr=%0b ser=%0b in=%h -> out=%h cnt=%0d done=%0b err=%0b",
             idx, v.init, v.ld, v.shl, v.shr, v.ser_in, v.reg_in, reg_out, shift_cnt, done, err);
  endtask

  task automatic idle();
    @(negedge clk);
    init = 0; ld = 0; shl = 0; shr = 0; ser_in = 0; reg_in = '0;
  endtask

  task automatic s_step(input logic i, input logic sl, input logic si, input string nm,
                        input logic [7:0] eout, input int ecnt, input logic ed);
    @(negedge clk);
    s_init = i; s_shl = sl; s_ser_in = si;
    @(posedge clk);
    #1;
    chk({nm, ".reg_out"}, 32'(s_reg_out), 32'(eout));
    chk({nm, ".cnt"},     32'(s_shift_cnt), 32'(ecnt));
    chk({nm, ".done"},    32'(s_done), 32'(ed));
    $display("%s out=%h cnt=%0d done=%0b", nm, s_reg_out, s_shift_cnt, s_done);
  endtask

  initial begin
    logic [15:0] model;

    rst = 1; init = 0; ld = 0; shl = 0; shr = 0; ser_in = 0; reg_in = '0;
    s_rst = 1; s_init = 0; s_ld = 0; s_shl = 0; s_shr = 0; s_ser_in = 0; s_reg_in = '0;
    repeat (2) @(negedge clk);
    rst = 0; s_rst = 0;
    #1;
    chk("reset.reg_out", 32'(reg_out), 32'h0);
    chk("reset.cnt",     32'(shift_cnt), 32'h0);
    chk("reset.done",    32'(done), 32'h0);
    chk("reset.err",     32'(err), 32'h0);
    $display("reset out=%h cnt=%0d done=%0b err=%0b", reg_out, shift_cnt, done, err);

    //   init ld shl shr ser  reg_in     exp_out    cnt done err
    add(1, 0, 0, 0, 0, 16'h0000, 16'h00FF, 0, 0, 0);
    add(0, 1, 0, 0, 0, 16'h8001, 16'h8001, 0, 0, 0);
    add(0, 0, 1, 0, 1, 16'h0000, 16'h0003, 1, 0, 0);
    add(0, 1, 0, 0, 0, 16'h0001, 16'h0001, 0, 0, 0);
    add(0, 0, 0, 1, 1, 16'h0000, 16'h8000, 1, 0, 0);
    add(0, 0, 0, 0, 0, 16'h0000, 16'h8000, 1, 0, 0);
    add(0, 1, 0, 0, 0, 16'h1234, 16'h1234, 0, 0, 0);
    add(0, 0, 1, 1, 1, 16'h0000, 16'h1234, 0, 0, 1);
    add(0, 1, 0, 0, 0, 16'h5678, 16'h5678, 0, 0, 1);
    add(1, 0, 0, 0, 0, 16'h0000, 16'h00FF, 0, 0, 0);
    add(1, 1, 1, 0, 1, 16'h5555, 16'h00FF, 0, 0, 0);
    add(0, 1, 0, 1, 1, 16'hAAAA, 16'hAAAA, 0, 0, 0);
    add(0, 1, 0, 0, 0, 16'hF000, 16'hF000, 0, 0, 0);
    model = 16'hF000;
    for (int k = 1; k <= 16; k++) begin
      model = model >> 1;
      add(0, 0, 0, 1, 0, 16'h0000, model, k, (k == 16), 0);
    end
    add(0, 0, 0, 1, 1, 16'h0000, 16'h0000, 16, 1, 0);
    add(0, 0, 1, 0, 1, 16'h0000, 16'h0000, 16, 1, 0);
    add(0, 1, 0, 0, 0, 16'h00C3, 16'h00C3, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);
    idle();

    // Async reset mid-run: 5 shifts, then rst between edges.
    apply('{init:0, ld:1, shl:0, shr:0, ser_in:0, reg_in:16'h0000,
            exp_out:16'h0000, exp_cnt:0, exp_done:0, exp_err:0}, 100);
    for (int k = 1; k <= 5; k++)
      apply('{init:0, ld:0, shl:1, shr:0, ser_in:1, reg_in:16'h0000,
              exp_out:16'((1 << k) - 1), exp_cnt:k, exp_done:0, exp_err:0}, 100 + k);
    idle();
    #2 rst = 1;
    #1;
    chk("async.reg_out", 32'(reg_out), 32'h0);
    chk("async.cnt",     32'(shift_cnt), 32'h0);
    $display("async rst out=%h cnt=%0d done=%0b", reg_out, shift_cnt, done);
    @(negedge clk);
    rst = 0;
    apply('{init:0, ld:0, shl:1, shr:0, ser_in:1, reg_in:16'h0000,
            exp_out:16'h0001, exp_cnt:1, exp_done:0, exp_err:0}, 110);
    idle();

    // 8-bit instance, INIT_VAL=0F, NSHIFT=3.
    s_step(1, 0, 0, "small.init", 8'h0F, 0, 0);
    s_step(0, 1, 0, "small.shl1", 8'h1E, 1, 0);
    s_step(0, 1, 0, "small.shl2", 8'h3C, 2, 0);
    s_step(0, 1, 0, "small.shl3", 8'h78, 3, 1);
    s_step(0, 1, 1, "small.shl4", 8'h78, 3, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
